conv2d_weight_ctrl: RTL and testbench

CONV2D_WEIGHT_CTRL -- requirements
Module: conv2d_weight_ctrl

---
 rtl/conv2d_pkg.sv | 21 ++
 rtl/pixel_pos_counter.sv | 57 +++++
 rtl/conv2d_weight_ctrl.sv | 179 +++++++++++++++++
 tb/tb_conv2d_weight_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_pkg
// Brief    : Shared FSM state type and kernel sizing helper for the conv2d
//            weight controller.
// Revision : 1.0
// ============================================================================
package conv2d_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } state_e;

    function automatic int kernel_area(input int kernel_width);
        return kernel_width * kernel_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_pos_counter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pos_counter
// Brief    : Raster x/y position tracker advancing one pixel per step.
// Revision : 1.0
// ============================================================================
module pixel_pos_counter #(
    parameter  int LineWidthPx = 160,
    parameter  int LineCountPx = 120,
    localparam int X_W         = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1,
    localparam int Y_W         = (LineCountPx > 1) ? $clog2(LineCountPx) : 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           step_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           at_origin_o,
    output logic           last_pixel_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(LineWidthPx - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(LineCountPx - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (step_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign at_origin_o  = (x_q == '0) && (y_q == '0);
    assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule
`default_nettype wire

// File: rtl/conv2d_weight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_weight_ctrl
// Brief    : Double-buffered kernel weight loader for conv2d; swaps the new
//            kernel in only at a frame boundary with no result held.
// Revision : 1.0
// ============================================================================
module conv2d_weight_ctrl
    import conv2d_pkg::*;
#(
    parameter  int LineWidthPx = 160,
    parameter  int LineCountPx = 120,
    parameter  int KernelWidth = 3,
    parameter  int WeightWidth = 2,
    localparam int KERNEL_AREA = kernel_area(KernelWidth)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     cfg_valid_i,
    output logic                                     cfg_ready_o,
    input  logic [WeightWidth-1:0]                   cfg_data_i,
    input  logic                                     cfg_last_i,
    input  logic                                     pix_fire_i,
    input  logic                                     conv_valid_i,
    output logic [KERNEL_AREA-1:0][WeightWidth-1:0]  weights_o,
    output logic                                     pending_o,
    output logic                                     swap_o,
    output logic                                     err_o,
    input  logic                                     err_clr_i
);

    localparam int              IDX_W    = (KERNEL_AREA > 1) ? $clog2(KERNEL_AREA) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_AREA - 1);
    localparam int              X_W      = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int              Y_W      = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;

    // Reset asserts asynchronously but releases two clocks after rst_ni rises.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_sync_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic           at_origin;
    logic           last_pixel;
    logic           unused_pos;

    pixel_pos_counter #(
        .LineWidthPx (LineWidthPx),
        .LineCountPx (LineCountPx)
    ) u_pos (
        .clk_i        (clk_i),
        .rst_ni       (rst_sync_n),
        .step_i       (pix_fire_i),
        .x_o          (pos_x),
        .y_o          (pos_y),
        .at_origin_o  (at_origin),
        .last_pixel_o (last_pixel)
    );

    assign unused_pos = ^{pos_x, pos_y, last_pixel};

    state_e                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [KERNEL_AREA-1:0][WeightWidth-1:0] shadow_q, shadow_d;
    logic [KERNEL_AREA-1:0][WeightWidth-1:0] active_q, active_d;
    logic                                  swap_q, swap_d;
    logic                                  err_q, err_d;

    logic cfg_fire;
    logic load_done;
    logic load_abort;
    logic swap_go;

    assign cfg_fire   = cfg_valid_i & cfg_ready_o;
    assign load_done  = cfg_fire & (idx_q == LAST_IDX);
    assign load_abort = cfg_fire & cfg_last_i & (idx_q != LAST_IDX);
    // Frame start with no result held is the only point where no output can mix banks.
    assign swap_go    = (state_q == PENDING) & at_origin & ~conv_valid_i;

    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (load_done) begin
                    state_d = PENDING;
                end else if (load_abort) begin
                    state_d = IDLE;
                end else if (cfg_fire) begin
                    state_d = LOAD;
                end
            end
            PENDING: begin
                if (swap_go) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready_o = 1'b1;
        pending_o   = 1'b0;
        case (state_q)
            PENDING: begin
                cfg_ready_o = 1'b0;
                pending_o   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = swap_go ? shadow_q : active_q;
        swap_d   = swap_go;
        if (load_done || load_abort) begin
            idx_d = '0;
        end else if (cfg_fire) begin
            idx_d = idx_q + 1'b1;
        end
        for (int i = 0; i < KERNEL_AREA; i++) begin
            if (cfg_fire && (idx_q == IDX_W'(i))) begin
                shadow_d[i] = cfg_data_i;
            end
        end
        // A new framing error takes priority over a clear in the same cycle.
        if (load_abort || (load_done && !cfg_last_i)) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            swap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            swap_q   <= swap_d;
            err_q    <= err_d;
        end
    end

    assign weights_o = active_q;
    assign swap_o    = swap_q;
    assign err_o     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_weight_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2d_weight_ctrl
// Brief    : Directed self-checking bench for conv2d_weight_ctrl on a 16x8 frame.
// Revision : 1.0
// ============================================================================
module tb_conv2d_weight_ctrl;

    localparam int LW = 16;
    localparam int LC = 8;
    localparam int KW = 3;
    localparam int WW = 2;
    localparam int KA = 9;

    typedef logic [KA-1:0][WW-1:0] kern_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_last;
    logic [WW-1:0] cfg_data;
    logic          pix_fire;
    logic          conv_valid;
    logic          err_clr;
    logic          cfg_ready;
    logic          pending;
    logic          swap;
    logic          err;
    kern_t         weights;

    conv2d_weight_ctrl #(
        .LineWidthPx (LW),
        .LineCountPx (LC),
        .KernelWidth (KW),
        .WeightWidth (WW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_data_i   (cfg_data),
        .cfg_last_i   (cfg_last),
        .pix_fire_i   (pix_fire),
        .conv_valid_i (conv_valid),
        .weights_o    (weights),
        .pending_o    (pending),
        .swap_o       (swap),
        .err_o        (err),
        .err_clr_i    (err_clr)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit saw_swap;
    bit saw_ready;

    kern_t k1, k2, k3, k4, k5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (swap === 1'b1) saw_swap = 1'b1;
    endtask

    task automatic fire_n(input int n);
        pix_fire = 1'b1;
        repeat (n) tick();
        pix_fire = 1'b0;
    endtask

    // Offers the first n words of k; cfg_last on the n-th word if last_on_final.
    task automatic load(input kern_t k, input int n, input bit last_on_final);
        cfg_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            cfg_data = k[i];
            cfg_last = last_on_final && (i == n - 1);
            tick();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < KA; i++) begin
            k1[i] = WW'(i + 1);
            k2[i] = WW'(8 - i);
            k3[i] = 2'b10;
            k4[i] = (i % 2 == 0) ? 2'b11 : 2'b01;
            k5[i] = 2'b01;
        end

        rst_n = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
        pix_fire = 1'b0; conv_valid = 1'b0; err_clr = 1'b0; saw_swap = 1'b0;
        repeat (2) tick();
        chk("rst_ready",   cfg_ready, 1'b1);
        chk("rst_pending", pending,   1'b0);
        chk("rst_swap",    swap,      1'b0);
        chk("rst_err",     err,       1'b0);
        chk("rst_weights", weights,   '0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Full load at origin with idle stream
        load(k1, KA, 1'b1);
        chk("t1_pending",     pending, 1'b1);
        chk("t1_no_swap_yet", swap,    1'b0);
        chk("t1_ready_low",   cfg_ready, 1'b0);
        chk("t1_w_old",       weights, '0);
        tick();
        chk("t1_swap",        swap,    1'b1);
        chk("t1_weights",     weights, k1);
        chk("t1_pending_clr", pending, 1'b0);
        tick();
        chk("t1_swap_once",   swap,    1'b0);

        // Load completes mid-frame at (5,2)
        fire_n(2 * LW + 5);
        load(k2, KA, 1'b1);
        chk("t2_pending", pending, 1'b1);
        saw_swap = 1'b0;
        fire_n(LW * LC - (2 * LW + 5));
        chk("t2_no_early_swap", saw_swap, 1'b0);
        chk("t2_w_held",        weights,  k1);
        pix_fire = 1'b1;
        tick();
        pix_fire = 1'b0;
        chk("t2_swap_with_fire", swap,    1'b1);
        chk("t2_weights",        weights, k2);
        tick();

        // Frame wraps while a result is held for 4 cycles; position now 1
        fire_n(119);
        load(k3, KA, 1'b1);
        fire_n(7);
        saw_swap   = 1'b0;
        conv_valid = 1'b1;
        pix_fire   = 1'b1;
        tick();
        pix_fire   = 1'b0;
        repeat (3) tick();
        chk("t3_no_swap_held", saw_swap, 1'b0);
        chk("t3_pending_held", pending,  1'b1);
        chk("t3_w_held",       weights,  k2);
        conv_valid = 1'b0;
        tick();
        chk("t3_swap",    swap,    1'b1);
        chk("t3_weights", weights, k3);

        // Short load framing error, then clear
        load(k4, 4, 1'b1);
        chk("t4_err",     err,       1'b1);
        chk("t4_idle",    pending,   1'b0);
        chk("t4_ready",   cfg_ready, 1'b1);
        chk("t4_w_kept",  weights,   k3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", err, 1'b0);
        cfg_valid = 1'b1; cfg_last = 1'b1; cfg_data = 2'b11; err_clr = 1'b1;
        tick();
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("t4_err_wins", err, 1'b1);
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr2", err, 1'b0);

        // Completion without last while off-origin, then words offered in PENDING
        fire_n(1);
        load(k4, KA, 1'b0);
        chk("t5_pending",  pending, 1'b1);
        chk("t5_err_nolast", err,   1'b1);
        saw_ready = 1'b0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cfg_data = WW'(i);
            cfg_last = (i == 9);
            #3;
            if (cfg_ready === 1'b1) saw_ready = 1'b1;
            tick();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0;
        chk("t5_ready_blocked", saw_ready, 1'b0);
        fire_n(LW * LC - 1);
        tick();
        chk("t5_swap",       swap,      1'b1);
        chk("t5_weights",    weights,   k4);
        chk("t5_ready_next", cfg_ready, 1'b1);
        chk("t5_err_sticky", err,       1'b1);

        // Reset in PENDING at (7,3)
        fire_n(3 * LW + 7);
        load(k5, KA, 1'b1);
        chk("t6_pending", pending, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pending", pending,   1'b0);
        chk("t6_rst_weights", weights,   '0);
        chk("t6_rst_err",     err,       1'b0);
        chk("t6_rst_ready",   cfg_ready, 1'b1);
        chk("t6_rst_swap",    swap,      1'b0);
        repeat (2) tick();
        rst_n    = 1'b1;
        saw_swap = 1'b0;
        repeat (8) tick();
        chk("t6_no_swap_after", saw_swap, 1'b0);
        chk("t6_w_zero",        weights,  '0);
        chk("t6_idle",          pending,  1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
